// File: rtl/ysyx_24070017_pkg.sv
// ysyx_24070017_pkg: shared widths, reset PC and FSM state encodings for the ysyx_24070017 core.
// Rev 1.0
`default_nettype none

package ysyx_24070017_pkg;

    localparam int          WORD_LENGTH = 32;
    localparam logic [31:0] RESET_PC    = 32'h8000_0000;

    localparam int          ST_W    = 2;
    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_WAIT = 2'd1;
    localparam logic [1:0]  ST_RESP = 2'd2;

    localparam int          CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/ysyx_24070017_Reg.sv
// ysyx_24070017_Reg: generic enable register with synchronous active-low reset to RESET_VAL.
// Rev 1.0
`default_nettype none

module ysyx_24070017_Reg #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic             wen
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_24070017_imem.sv
// ysyx_24070017_imem: instruction memory with valid/ready fetch channel, fixed latency and backdoor load port.
// Rev 1.0
`default_nettype none

module ysyx_24070017_imem
    import ysyx_24070017_pkg::*;
#(
    parameter int                     WORD_LENGTH = ysyx_24070017_pkg::WORD_LENGTH,
    parameter logic [WORD_LENGTH-1:0] BASE        = WORD_LENGTH'(RESET_PC),
    parameter int                     DEPTH       = 1024,
    parameter int                     LAT         = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WORD_LENGTH-1:0] req_addr,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_LENGTH-1:0] resp_inst,
    output logic                   resp_err,
    input  logic                   ld_en,
    input  logic [WORD_LENGTH-1:0] ld_addr,
    input  logic [WORD_LENGTH-1:0] ld_data
);

    localparam int                     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_LENGTH-1:0] DEPTH_W = WORD_LENGTH'(DEPTH);
    localparam logic [CNT_W-1:0]       CNT_INI = CNT_W'((LAT > 1) ? (LAT - 2) : 0);

    logic [WORD_LENGTH-1:0] mem [DEPTH];

    logic [ST_W-1:0]        state;
    logic [CNT_W-1:0]       cnt;

    logic [WORD_LENGTH-1:0] req_word;
    logic [WORD_LENGTH-1:0] ld_word;
    logic                   req_bad;
    logic                   ld_bad;
    logic                   accept;
    logic [WORD_LENGTH-1:0] rd_data;
    logic [WORD_LENGTH:0]   resp_d;
    logic [WORD_LENGTH:0]   resp_q;

    // The below-BASE test guards the subtraction, so a wrapped offset never aliases into range.
    function automatic logic addr_bad(input logic [WORD_LENGTH-1:0] addr,
                                      input logic [WORD_LENGTH-1:0] word);
        return (addr[1:0] != 2'b00) || (addr < BASE) || (word >= DEPTH_W);
    endfunction

    assign req_word = (req_addr - BASE) >> 2;
    assign ld_word  = (ld_addr  - BASE) >> 2;
    assign req_bad  = addr_bad(req_addr, req_word);
    assign ld_bad   = addr_bad(ld_addr, ld_word);

    assign req_ready  = rst && (state == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == ST_RESP);

    assign rd_data = req_bad ? '0 : mem[req_word[IDX_W-1:0]];
    assign resp_d  = {req_bad, rd_data};

    // Storage is deliberately left out of reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_bad) begin
            mem[ld_word[IDX_W-1:0]] <= ld_data;
        end
    end

    ysyx_24070017_Reg #(
        .WIDTH     (WORD_LENGTH + 1),
        .RESET_VAL ('0)
    ) u_resp_reg (
        .clk  (clk),
        .rst  (rst),
        .din  (resp_d),
        .dout (resp_q),
        .wen  (accept)
    );

    assign resp_err  = resp_q[WORD_LENGTH];
    assign resp_inst = resp_q[WORD_LENGTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (LAT <= 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_INI;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24070017_imem.sv
// tb_ysyx_24070017_imem: directed checks of a LAT=1 and a LAT=3 instance sharing clock, reset and load port.
// Rev 1.0
`default_nettype none

module tb_ysyx_24070017_imem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic        req_valid1 = 1'b0, req_ready1, resp_valid1, resp_ready1 = 1'b0, resp_err1;
    logic [31:0] req_addr1 = '0, resp_inst1;
    logic        req_valid3 = 1'b0, req_ready3, resp_valid3, resp_ready3 = 1'b0, resp_err3;
    logic [31:0] req_addr3 = '0, resp_inst3;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ysyx_24070017_imem #(.LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_inst(resp_inst1), .resp_err(resp_err1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ysyx_24070017_imem #(.LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_inst(resp_inst3), .resp_err(resp_err3),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // One LAT=1 request followed by an immediate handshake; returns what was observed.
    task automatic fetch1(input logic [31:0] a, output logic v, output logic [31:0] inst, output logic err);
        req_valid1 = 1'b1; req_addr1 = a;
        tick();
        req_valid1 = 1'b0;
        v = resp_valid1; inst = resp_inst1; err = resp_err1;
        resp_ready1 = 1'b1;
        tick();
        resp_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        if (req_ready1 !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %0b want 0", req_ready1); end
        tests_run++;
        if (resp_valid1 !== 1'b0 || resp_valid3 !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0b/%0b want 0/0", resp_valid1, resp_valid3); end
        tests_run++;
        if (resp_inst1 !== 32'h0 || resp_err1 !== 1'b0) begin tests_failed++; $display("FAIL rst_resp: got %h/%0b want 0/0", resp_inst1, resp_err1); end
        tests_run++;
        rst = 1'b1;
        #1;
        if (req_ready1 !== 1'b1 || req_ready3 !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %0b/%0b want 1/1", req_ready1, req_ready3); end
        tests_run++;
    endtask

    task automatic test_latency();
        do_load(32'h8000_0000, 32'h0010_0093);
        tick(); tick();
        req_valid1 = 1'b1; req_addr1 = 32'h8000_0000;
        tick();
        req_valid1 = 1'b0;
        if (resp_valid1 !== 1'b1) begin tests_failed++; $display("FAIL lat1_valid: got %0b want 1", resp_valid1); end
        tests_run++;
        if (resp_inst1 !== 32'h0010_0093 || resp_err1 !== 1'b0) begin tests_failed++; $display("FAIL lat1_data: got %h/%0b want 00100093/0", resp_inst1, resp_err1); end
        tests_run++;
        if (req_ready1 !== 1'b0) begin tests_failed++; $display("FAIL lat1_busy: got %0b want 0", req_ready1); end
        tests_run++;
        resp_ready1 = 1'b1;
        tick();
        resp_ready1 = 1'b0;
        if (resp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin tests_failed++; $display("FAIL lat1_done: got valid %0b ready %0b want 0 1", resp_valid1, req_ready1); end
        tests_run++;
        if (resp_inst1 !== 32'h0010_0093) begin tests_failed++; $display("FAIL lat1_hold: got %h want 00100093", resp_inst1); end
        tests_run++;
    endtask

    task automatic test_backpressure();
        do_load(32'h8000_0004, 32'h1234_5678);
        req_valid3 = 1'b1; req_addr3 = 32'h8000_0004;
        tick();
        for (int i = 0; i < 2; i++) begin
            if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b0) begin tests_failed++; $display("FAIL lat3_wait%0d: got valid %0b ready %0b want 0 0", i, resp_valid3, req_ready3); end
            tests_run++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid3 !== 1'b1 || resp_inst3 !== 32'h1234_5678 || req_ready3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL lat3_hold%0d: got valid %0b inst %h ready %0b want 1 12345678 0", i, resp_valid3, resp_inst3, req_ready3);
            end
            tests_run++;
            tick();
        end
        resp_ready3 = 1'b1;
        tick();
        if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin tests_failed++; $display("FAIL lat3_handshake: got valid %0b ready %0b want 0 1", resp_valid3, req_ready3); end
        tests_run++;
        req_valid3 = 1'b0; resp_ready3 = 1'b0;
        tick(); tick(); tick();
        if (resp_valid3 !== 1'b0) begin tests_failed++; $display("FAIL lat3_no_reaccept: got %0b want 0", resp_valid3); end
        tests_run++;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic v, e;
        logic [31:0] d;
        addrs[0] = 32'h8000_0002; addrs[1] = 32'h7FFF_FFFC; addrs[2] = 32'h8000_1000;
        for (int i = 0; i < 3; i++) begin
            fetch1(32'h8000_0000, v, d, e);
            fetch1(addrs[i], v, d, e);
            if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
                tests_failed++;
                $display("FAIL err_%h: got valid %0b inst %h err %0b want 1 0 1", addrs[i], v, d, e);
            end
            tests_run++;
        end
        do_load(32'h8000_0FFC, 32'hCAFE_F00D);
        fetch1(32'h8000_0FFC, v, d, e);
        if (v !== 1'b1 || d !== 32'hCAFE_F00D || e !== 1'b0) begin tests_failed++; $display("FAIL last_word: got valid %0b inst %h err %0b want 1 cafef00d 0", v, d, e); end
        tests_run++;
    endtask

    task automatic test_collision();
        logic v, e;
        logic [31:0] d;
        do_load(32'h8000_0010, 32'h1111_1111);
        ld_en = 1'b1; ld_addr = 32'h8000_0010; ld_data = 32'hDEAD_BEEF;
        fetch1(32'h8000_0010, v, d, e);
        ld_en = 1'b0;
        if (d !== 32'h1111_1111 || e !== 1'b0) begin tests_failed++; $display("FAIL collide_old: got %h/%0b want 11111111/0", d, e); end
        tests_run++;
        fetch1(32'h8000_0010, v, d, e);
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL collide_new: got %h want deadbeef", d); end
        tests_run++;
        do_load(32'h8000_0012, 32'h0000_0000);
        fetch1(32'h8000_0010, v, d, e);
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ld_misaligned_ignored: got %h want deadbeef", d); end
        tests_run++;
    endtask

    task automatic test_reset_in_wait();
        logic v, e;
        logic [31:0] d;
        req_valid3 = 1'b1; req_addr3 = 32'h8000_0004;
        tick();
        req_valid3 = 1'b0;
        rst = 1'b0;
        tick();
        if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b0 || resp_inst3 !== 32'h0) begin
            tests_failed++;
            $display("FAIL wait_reset: got valid %0b ready %0b inst %h want 0 0 0", resp_valid3, req_ready3, resp_inst3);
        end
        tests_run++;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin tests_failed++; $display("FAIL wait_dropped%0d: got valid %0b ready %0b want 0 1", i, resp_valid3, req_ready3); end
            tests_run++;
            tick();
        end
        fetch1(32'h8000_0010, v, d, e);
        if (d !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL mem_survives_reset: got %h want deadbeef", d); end
        tests_run++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs[0] = 32'h8000_0000; datas[0] = 32'h0010_0093;
        addrs[1] = 32'h8000_0010; datas[1] = 32'hDEAD_BEEF;
        addrs[2] = 32'h8000_0FFC; datas[2] = 32'hCAFE_F00D;
        resp_ready1 = 1'b1; req_valid1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr1 = addrs[i / 2];
            tick();
            if (resp_valid1 !== ((i % 2) == 0)) begin tests_failed++; $display("FAIL b2b_valid%0d: got %0b want %0b", i, resp_valid1, (i % 2) == 0); end
            tests_run++;
            if ((i % 2) == 0 && resp_inst1 !== datas[i / 2]) begin tests_failed++; $display("FAIL b2b_inst%0d: got %h want %h", i, resp_inst1, datas[i / 2]); end
            tests_run++;
        end
        req_valid1 = 1'b0; resp_ready1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_errors();
        test_collision();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_24070017_imem.md
YSYX_24070017_IMEM -- requirements
Module: ysyx_24070017_imem

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 32, giving the data and address width.
REQ-002 The block SHALL have parameter BASE, default 32'h80000000, giving the byte address of word 0.
REQ-003 The block SHALL have parameter DEPTH, default 1024, giving the storage size in words.
REQ-004 The block SHALL have parameter LAT, default 1 (legal range 1..15), giving the request-to-response latency in cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low (0 = reset).
REQ-007 The block SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_addr (input, WORD_LENGTH): the fetch request channel, where req_addr is a byte address.
REQ-008 The block SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_inst (output, WORD_LENGTH) and resp_err (output, 1): the fetch response channel.
REQ-009 The block SHALL have ports ld_en (input, 1), ld_addr (input, WORD_LENGTH) and ld_data (input, WORD_LENGTH): the backdoor program-load write port.

Function
REQ-010 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-011 In IDLE, req_ready SHALL be 1; in WAIT, in RESP and during reset it SHALL be 0.
REQ-012 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-013 On acceptance, the block SHALL capture the word at index (req_addr-BASE)>>2, plus the error flag, into the response register in the same edge.
REQ-014 A request SHALL be in error if req_addr[1:0]!=0, req_addr<BASE, or (req_addr-BASE)>>2 >= DEPTH.
REQ-015 For an error request, the block SHALL return resp_inst=0 and resp_err=1, and the storage SHALL NOT be read.
REQ-016 For a request accepted at edge T, resp_valid SHALL first be 1 in the cycle following edge T+LAT-1 (exactly LAT cycles of latency).
REQ-017 On acceptance, LAT=1 SHALL go IDLE->RESP; LAT>1 SHALL go IDLE->WAIT with a down-counter loaded with LAT-2.
REQ-018 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go WAIT->RESP when the counter is 0.
REQ-019 In RESP, resp_valid=1, and resp_inst and resp_err SHALL stay stable until a handshake (resp_valid & resp_ready).
REQ-020 A response handshake SHALL take the FSM RESP->IDLE; the block SHALL hold only one request outstanding, with no new acceptance in the handshake cycle.
REQ-021 Outside RESP, resp_valid SHALL be 0; resp_inst and resp_err SHALL keep their last values.
REQ-022 With ld_en=1 and ld_addr aligned and in range, the block SHALL write ld_data to the addressed word at the edge; otherwise the write SHALL be ignored silently.
REQ-023 When a load write and a request acceptance hit the same word at the same edge, the response SHALL carry the old data.
REQ-024 The load port SHALL be accepted in every FSM state.
REQ-025 Address arithmetic SHALL be WORD_LENGTH-bit unsigned, with the req_addr<BASE check done before subtraction, so there is no wrap-around alias.

Reset
REQ-026 While rst=0 at an edge, the FSM SHALL go to IDLE, with resp_valid=0, resp_inst=0, resp_err=0 and the counter at 0.
REQ-027 req_ready SHALL be 0 in any cycle where rst=0.
REQ-028 Reset asserted in WAIT or RESP SHALL drop the pending response without emitting it.
REQ-029 Storage contents SHALL NOT be affected by reset.

Structure
REQ-030 WORD_LENGTH, the reset PC constant 32'h80000000 (used as the BASE default) and the FSM state encoding SHALL live in the shared ysyx_24070017 package.
REQ-031 The response data and error register SHALL be an instance of the existing ysyx_24070017_Reg, with write enable = request accept; no other sub-module is used.

Verification
REQ-032 Latency check: load 0x00100093 at 0x80000000, LAT=1, issue req 0x80000000 at cycle 5 -> resp_valid=1 in cycle 6 with inst 0x00100093 and err=0.
REQ-033 Parameter and backpressure check: LAT=3, resp_ready=0 for 4 cycles -> resp_valid is first 1 three cycles after acceptance, resp_inst is stable throughout, and req_ready=0 until the handshake.
REQ-034 Error check: requests 0x80000002, 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> each returns err=1, inst=0.
REQ-035 Load collision check: ld_en writes 0xDEADBEEF to 0x80000010 at the same edge a request to 0x80000010 is accepted -> response carries the old value; a following request returns 0xDEADBEEF.
REQ-036 Reset check: rst=0 asserted in WAIT -> the next cycle has resp_valid=0 and, after rst=1, req_ready=1; back-to-back requests with resp_ready=1 and LAT=1 complete one every 2 cycles.
